// File: rtl/single_to_fix.sv
// IEEE 754 single-precision to unsigned fixed-point converter.
// Out-of-range operands saturate; normal values shift right by up to four bits per cycle.
module single_to_fix #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    localparam int W          = INT_WIDTH + FRACT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_single,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_fixed,
    output logic         out_ovf,
    output logic         out_unf,
    output logic         out_inv
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic signed [9:0] INT_S    = 10'(INT_WIDTH);
    localparam logic signed [9:0] FR_S     = 10'(FRACT_WIDTH);
    localparam logic signed [9:0] NEG_FR_S = 10'(-FRACT_WIDTH);

    state_t              state_r, state_nx;
    logic [4:0]          cnt_r, cnt_nx;
    logic [23:0]         sh_r, sh_nx;
    logic [W-1:0]        fixed_r, fixed_nx;
    logic                ovf_r, ovf_nx;
    logic                unf_r, unf_nx;
    logic                inv_r, inv_nx;
    logic                in_ready_r;
    logic                out_valid_r;

    logic                sgn_s;
    logic [7:0]          exp_s;
    logic [22:0]         man_s;
    logic [23:0]         sig_s;
    logic signed [9:0]   exp_unb_s;
    logic signed [9:0]   rsh_s;
    logic [4:0]          step_s;

    // Operand field split; rsh_s is the total right shift for a normal operand.
    always_comb begin
        sgn_s     = in_single[31];
        exp_s     = in_single[30:23];
        man_s     = in_single[22:0];
        sig_s     = {1'b1, man_s};
        exp_unb_s = $signed({2'b00, exp_s}) - 10'sd127;
        rsh_s     = 10'sd23 - FR_S - exp_unb_s;
        step_s    = (cnt_r > 5'd4) ? 5'd4 : cnt_r;
    end

    // Next-state, datapath and result/flag update.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        sh_nx    = sh_r;
        fixed_nx = fixed_r;
        ovf_nx   = ovf_r;
        unf_nx   = unf_r;
        inv_nx   = inv_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    fixed_nx = {W{1'b0}};
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                    inv_nx   = 1'b0;
                    cnt_nx   = 5'd0;
                    state_nx = ST_DONE;
                    // First match wins: NaN and negatives are invalid before +Inf saturation.
                    if (exp_s == 8'hFF && man_s != 23'd0) begin
                        inv_nx = 1'b1;
                    end else if (sgn_s && (exp_s != 8'd0 || man_s != 23'd0)) begin
                        inv_nx = 1'b1;
                    end else if (exp_s == 8'hFF) begin
                        fixed_nx = {W{1'b1}};
                        ovf_nx   = 1'b1;
                    end else if (exp_s == 8'd0) begin
                        unf_nx = (man_s != 23'd0);
                    end else if (exp_unb_s >= INT_S) begin
                        fixed_nx = {W{1'b1}};
                        ovf_nx   = 1'b1;
                    end else if (exp_unb_s < NEG_FR_S) begin
                        unf_nx = 1'b1;
                    end else if (rsh_s == 10'sd0) begin
                        fixed_nx = sig_s[W-1:0];
                    end else begin
                        state_nx = ST_SHIFT;
                        cnt_nx   = rsh_s[4:0];
                        sh_nx    = sig_s;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sh_nx  = sh_r >> step_s;
                cnt_nx = cnt_r - step_s;
                if (cnt_nx == 5'd0) begin
                    state_nx = ST_DONE;
                    fixed_nx = sh_nx[W-1:0];
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            sh_r        <= 24'd0;
            fixed_r     <= {W{1'b0}};
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            inv_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            sh_r        <= sh_nx;
            fixed_r     <= fixed_nx;
            ovf_r       <= ovf_nx;
            unf_r       <= unf_nx;
            inv_r       <= inv_nx;
            in_ready_r  <= (state_nx == ST_IDLE);
            out_valid_r <= (state_nx == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_fixed = fixed_r;
    assign out_ovf   = ovf_r;
    assign out_unf   = unf_r;
    assign out_inv   = inv_r;

endmodule

// File: tb/tb_single_to_fix.sv
// Directed-vector bench for single_to_fix (INT_WIDTH=12, FRACT_WIDTH=4).
module tb_single_to_fix;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_single;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fixed;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inv;

    int checks = 0;
    int errors = 0;

    single_to_fix #(.INT_WIDTH(12), .FRACT_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_single (in_single),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fixed (out_fixed),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inv   (out_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [15:0] fx;
        logic [2:0]  flg;   // {ovf, unf, inv}
        int          lat;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request with out_ready high; verify result, flags, latency and return to idle.
    task automatic run_vec(input logic [31:0] din, input logic [15:0] fx,
                           input logic [2:0] flg, input int lat_exp, input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_single = din;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_single = ~din;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " fixed"}, 32'(out_fixed), 32'(fx));
        check({tag, " flags"}, 32'({out_ovf, out_unf, out_inv}), 32'(flg));
        @(posedge clk); #1;
        check({tag, " drained"}, 32'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{32'h3F800000, 16'h0010, 3'b000, 6};   // 1.0
        vecs[1]  = '{32'h40200000, 16'h0028, 3'b000, 6};   // 2.5
        vecs[2]  = '{32'h457FF000, 16'hFFF0, 3'b000, 3};   // 4095.0
        vecs[3]  = '{32'h3D800000, 16'h0001, 3'b000, 7};   // 0.0625
        vecs[4]  = '{32'h45800000, 16'hFFFF, 3'b100, 1};   // 4096.0
        vecs[5]  = '{32'h7F800000, 16'hFFFF, 3'b100, 1};   // +Inf
        vecs[6]  = '{32'h3D000000, 16'h0000, 3'b010, 1};   // 0.03125
        vecs[7]  = '{32'h00000000, 16'h0000, 3'b000, 1};   // +0
        vecs[8]  = '{32'hBF800000, 16'h0000, 3'b001, 1};   // -1.0
        vecs[9]  = '{32'h7FC00000, 16'h0000, 3'b001, 1};   // NaN
        vecs[10] = '{32'h80000000, 16'h0000, 3'b000, 1};   // -0.0
        vecs[11] = '{32'hFF800000, 16'h0000, 3'b001, 1};   // -Inf
        vecs[12] = '{32'h00000001, 16'h0000, 3'b010, 1};   // +denormal
        vecs[13] = '{32'h80000001, 16'h0000, 3'b001, 1};   // -denormal
        vecs[14] = '{32'h7F800001, 16'h0000, 3'b001, 1};   // NaN, smallest payload
        vecs[15] = '{32'h3FC00000, 16'h0018, 3'b000, 6};   // 1.5
        vecs[16] = '{32'h45000000, 16'h8000, 3'b000, 3};   // 2048.0
        vecs[17] = '{32'h457FFFFF, 16'hFFFF, 3'b000, 3};   // just below 4096, no ovf
        vecs[18] = '{32'h3D7FFFFF, 16'h0000, 3'b010, 1};   // just below 0.0625
        vecs[19] = '{32'h40490FDB, 16'h0032, 3'b000, 6};   // pi -> 3.125
        vecs[20] = '{32'h3E000000, 16'h0002, 3'b000, 7};   // 0.125
        vecs[21] = '{32'h41200000, 16'h00A0, 3'b000, 5};   // 10.0
        vecs[22] = '{32'h44800000, 16'h4000, 3'b000, 4};   // 1024.0

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_single = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset fixed", 32'(out_fixed), 32'd0);
        check("reset flags", 32'({out_ovf, out_unf, out_inv}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i].din, vecs[i].fx, vecs[i].flg, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Backpressure: hold result for 10 cycles while a second request waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_single = 32'h3F800000;
        @(posedge clk); #1;
        in_single = 32'h40200000;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd6);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp hold valid %0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp hold in_ready %0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp hold fixed %0d", k), 32'(out_fixed), 32'h0010);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp drained", 32'({out_valid, in_ready}), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp second latency", 32'(lat), 32'd6);
        check("bp second fixed", 32'(out_fixed), 32'h0028);
        @(posedge clk); #1;

        // Reset in the middle of shifting 1.0 must drop the result.
        in_valid  = 1'b1;
        in_single = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid reset fixed", 32'(out_fixed), 32'd0);
        check("mid reset handshake", 32'({out_valid, in_ready}), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        check("mid reset no output", 32'(seen), 32'd0);
        run_vec(32'h40200000, 16'h0028, 3'b000, 6, "after reset 2.5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
